// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite OAM DMA controller: state encoding and defaults.
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_e;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
    localparam int          XFER_LEN_DEF      = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller and bus arbiter between the 6502 core and the system bus.
// A CPU write to the DMA register stalls the CPU, then the block alternates
// READ (from page {val,idx}) and WRITE (to the OAM data port) for XFER_LEN bytes.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
    parameter int          XFER_LEN      = XFER_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    input  logic [7:0]  bus_din,
    output logic        dma_active
);

    // Terminal index; the counter never relies on 8-bit overflow to wrap.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] data_q,  data_d;
    logic       rdy_q,   rdy_d;
    logic       parity_q;

    // Free-running get/put parity; 0 marks a get cycle, independent of DMA state.
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ~parity_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic: trigger, halt on the first CPU read, align to a get cycle, copy.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = HALT;
                    rdy_d   = 1'b0;
                end
            end
            HALT: begin
                // The 6502 only halts on a read, so writes keep us here.
                if (!cpu_we) state_d = parity_q ? READ : ALIGN;
            end
            ALIGN: state_d = READ;
            READ: begin
                data_d  = bus_din;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    idx_d   = 8'h00;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // Bus arbitration: CPU passthrough unless the DMA owns the bus.
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        if (state_q == READ) begin
            bus_addr = {page_q, idx_q};
            bus_we   = 1'b0;
        end else if (state_q == WRITE) begin
            bus_addr = OAM_DATA_ADDR;
            bus_dout = data_q;
            bus_we   = 1'b1;
        end
    end

    assign cpu_rdy    = rdy_q;
    assign dma_active = (state_q == READ) || (state_q == WRITE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory returns idx^8'h5A on every page.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic [7:0]  bus_din;
    logic        dma_active;

    int errors = 0;
    int checks = 0;

    oam_dma_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_we     (cpu_we),
        .cpu_rdy    (cpu_rdy),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_we     (bus_we),
        .bus_din    (bus_din),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    assign bus_din = bus_addr[7:0] ^ 8'h5A;

    // Reference get/put parity: cleared by reset, toggles every edge otherwise.
    logic model_par = 1'b0;
    always @(posedge clk) model_par <= reset ? 1'b0 : ~model_par;

    // Bus observer, sampled mid-cycle.
    logic [7:0]  wq[$];
    logic [15:0] rq[$];
    int rdy_low, pre_cnt, bad_par, bad_rdout;
    always @(negedge clk) begin
        if (!cpu_rdy) rdy_low++;
        if (!cpu_rdy && !dma_active) pre_cnt++;
        if (bus_we && bus_addr == 16'h2004) wq.push_back(bus_dout);
        if (dma_active && !bus_we) begin
            rq.push_back(bus_addr);
            if (model_par) bad_par++;
            if (bus_dout !== cpu_dout) bad_rdout++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        rq.delete();
        rdy_low = 0; pre_cnt = 0; bad_par = 0; bad_rdout = 0;
    endtask

    task automatic cpu_idle();
        cpu_addr = 16'h8000; cpu_dout = 8'hEE; cpu_we = 1'b0;
    endtask

    // Advance until the parity seen by the trigger edge equals v.
    task automatic wait_par(input logic v);
        while (model_par !== v) tick();
    endtask

    // Issue the trigger write; the edge after this cycle starts HALT.
    task automatic trigger(input logic [7:0] pg);
        cpu_addr = 16'h4014; cpu_dout = pg; cpu_we = 1'b1;
        tick();
    endtask

    // Wait (bounded) for the CPU to be released.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (cpu_rdy) begin ok = 1'b1; break; end
        end
        tick();
    endtask

    function automatic int count_bad_data();
        int bad = 0;
        foreach (wq[i]) if (wq[i] !== (8'(i) ^ 8'h5A)) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        int bad = 0;
        bit ok;
        reset = 1'b1; cpu_idle();
        tick(); tick();
        checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
        checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", dma_active); end
        reset = 1'b0;
        tick();
        // start a transfer, then reset it for two cycles mid-stream
        trigger(8'h02);
        cpu_idle();
        repeat (20) tick();
        checks++; if (dma_active !== 1'b1) begin errors++; $display("FAIL reset_pre_active: got %b want 1", dma_active); end
        reset = 1'b1;
        tick();
        checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            errors++; $display("FAIL reset_mid_immediate: rdy=%b active=%b want rdy=1 active=0", cpu_rdy, dma_active); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = 16'h1000 + 16'(i * 16'h0111); cpu_dout = 8'(i * 7); cpu_we = i[0];
            @(negedge clk);
            if (bus_addr !== cpu_addr || bus_dout !== cpu_dout || bus_we !== cpu_we ||
                cpu_rdy !== 1'b1 || dma_active !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_passthrough: %0d bad cycles want 0", bad); end
        cpu_idle();
        ok = 1'b1;
    endtask

    task automatic test_basic_transfer();
        bit ok;
        wait_par(1'b1);            // HALT sits on parity 0 -> ALIGN inserted
        clear_mon();
        trigger(8'h02);
        cpu_idle();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: cpu_rdy never returned"); end
        checks++; if (rdy_low != 514) begin errors++; $display("FAIL basic_latency: got %0d want 514", rdy_low); end
        checks++; if (wq.size() != 256) begin errors++; $display("FAIL basic_wcount: got %0d want 256", wq.size()); end
        checks++; if (count_bad_data() != 0) begin errors++; $display("FAIL basic_data: %0d bad bytes want 0", count_bad_data()); end
        checks++; if (rq.size() != 256 || rq[0] !== 16'h0200 || rq[rq.size()-1] !== 16'h02FF) begin
            errors++; $display("FAIL basic_raddr: n=%0d first=%h last=%h want 256 0200 02ff",
                               rq.size(), rq.size() ? rq[0] : 16'h0, rq.size() ? rq[rq.size()-1] : 16'h0); end
        checks++; if (bad_rdout != 0) begin errors++; $display("FAIL basic_read_dout: %0d bad want 0", bad_rdout); end
        checks++; if (pre_cnt != 2) begin errors++; $display("FAIL basic_halt_align: got %0d want 2", pre_cnt); end
    endtask

    task automatic test_odd_alignment();
        bit ok;
        wait_par(1'b0);            // HALT sits on parity 1 -> straight to READ
        clear_mon();
        trigger(8'h02);
        cpu_idle();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL odd_timeout: cpu_rdy never returned"); end
        checks++; if (rdy_low != 513) begin errors++; $display("FAIL odd_latency: got %0d want 513", rdy_low); end
        checks++; if (bad_par != 0) begin errors++; $display("FAIL odd_read_parity: %0d reads off parity 0", bad_par); end
        checks++; if (wq.size() != 256 || count_bad_data() != 0) begin
            errors++; $display("FAIL odd_data: n=%0d bad=%0d want 256 0", wq.size(), count_bad_data()); end
    endtask

    task automatic test_halt_deferral();
        bit ok;
        int bad = 0;
        wait_par(1'b1);            // 4 HALT cycles end on parity 1 -> no ALIGN
        clear_mon();
        trigger(8'h02);
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 16'h01F0 + 16'(i); cpu_dout = 8'hC0 + 8'(i); cpu_we = 1'b1;
            @(negedge clk);
            if (bus_addr !== cpu_addr || bus_we !== 1'b1 || bus_dout !== cpu_dout ||
                dma_active !== 1'b0 || cpu_rdy !== 1'b0) bad++;
            tick();
        end
        cpu_idle();
        wait_idle(ok);
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_passthrough: %0d bad cycles want 0", bad); end
        checks++; if (!ok) begin errors++; $display("FAIL halt_timeout: cpu_rdy never returned"); end
        checks++; if (pre_cnt != 4) begin errors++; $display("FAIL halt_len: got %0d want 4", pre_cnt); end
        checks++; if (rdy_low != 516) begin errors++; $display("FAIL halt_latency: got %0d want 516", rdy_low); end
        checks++; if (wq.size() != 256 || count_bad_data() != 0) begin
            errors++; $display("FAIL halt_data: n=%0d bad=%0d want 256 0", wq.size(), count_bad_data()); end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        bit found = 1'b0;
        clear_mon();
        trigger(8'h02);
        cpu_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dma_active && bus_we && bus_addr == 16'h2004 && bus_dout == (8'd100 ^ 8'h5A)) begin
                found = 1'b1; break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL midrst_find: byte 100 write never seen"); end
        reset = 1'b1;
        tick();
        checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || bus_addr !== cpu_addr) begin
            errors++; $display("FAIL midrst_idle: rdy=%b active=%b addr=%h want 1 0 %h",
                               cpu_rdy, dma_active, bus_addr, cpu_addr); end
        reset = 1'b0;
        clear_mon();
        repeat (20) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL midrst_nowrite: got %0d writes want 0", wq.size()); end
        clear_mon();
        trigger(8'h02);
        cpu_idle();
        wait_idle(ok);
        checks++; if (!ok || wq.size() != 256 || count_bad_data() != 0 || rq[0] !== 16'h0200) begin
            errors++; $display("FAIL midrst_restart: ok=%b n=%0d bad=%0d first=%h want 1 256 0 0200",
                               ok, wq.size(), count_bad_data(), rq.size() ? rq[0] : 16'h0); end
    endtask

    task automatic test_passthrough();
        int bad = 0;
        logic [15:0] addrs [4];
        logic        wes   [4];
        addrs[0] = 16'h4015; wes[0] = 1'b1;
        addrs[1] = 16'h4014; wes[1] = 1'b0;
        addrs[2] = 16'h2004; wes[2] = 1'b0;
        addrs[3] = 16'h4013; wes[3] = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            cpu_addr = addrs[i]; cpu_dout = 8'h02 + 8'(i); cpu_we = wes[i];
            @(negedge clk);
            if (bus_addr !== cpu_addr || bus_dout !== cpu_dout || bus_we !== cpu_we) bad++;
            tick();
        end
        cpu_idle();
        repeat (4) tick();
        checks++; if (bad != 0) begin errors++; $display("FAIL pass_mirror: %0d bad cycles want 0", bad); end
        checks++; if (rdy_low != 0 || cpu_rdy !== 1'b1) begin
            errors++; $display("FAIL pass_rdy: low_cycles=%0d rdy=%b want 0 1", rdy_low, cpu_rdy); end
        checks++; if (rq.size() != 0) begin errors++; $display("FAIL pass_nodma: %0d dma reads want 0", rq.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_basic_transfer();
        test_odd_alignment();
        test_halt_deferral();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
